// File: rtl/led_pwm_fader_if.sv
// Fader control/status bundle: target level and enable in, PWM pin and ramp status out.
interface led_pwm_fader_if #(
   parameter int PWM_BITS = 8
);
   logic                led_in;
   logic                en;
   logic                led;
   logic [PWM_BITS-1:0] level;
   logic                busy;

   modport master (output led_in, en, input led, level, busy);
   modport slave  (input led_in, en, output led, level, busy);
endinterface

// File: rtl/led_pwm_fader.sv
// Linear brightness ramp toward the blinker's led level, rendered as PWM.
// Define LED_PWM_FADER_GAMMA_EN for a quadratic duty curve (adds one cycle of PWM latency).
module led_pwm_fader #(
   parameter int CLK_FREQ_KHz = 50000,
   parameter int RAMP_MS      = 250,
   parameter int PWM_BITS     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   led_pwm_fader_if.slave       bus
);
   localparam int STEP_RAW    = (CLK_FREQ_KHz * RAMP_MS) / ((1 << PWM_BITS) - 1);
   localparam int STEP_CYCLES = (STEP_RAW < 1) ? 1 : STEP_RAW;
   localparam int CW          = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

   localparam logic [CW-1:0]       STEP_LAST = CW'(STEP_CYCLES - 1);
   localparam logic [PWM_BITS-1:0] MAX       = '1;
   localparam logic [PWM_BITS-1:0] PC_LAST   = PWM_BITS'((1 << PWM_BITS) - 2);
   localparam logic [PWM_BITS-1:0] ONE       = PWM_BITS'(1);

   typedef enum logic [1:0] {OFF, UP, ON, DOWN} state_t;

   state_t              state, state_nxt;
   logic [PWM_BITS-1:0] level, level_nxt;
   logic [CW-1:0]       cnt, cnt_nxt;
   logic [PWM_BITS-1:0] pc;
   logic [PWM_BITS-1:0] duty;
   logic                busy_q, led_q;
   logic                tick;

   assign tick = (cnt == STEP_LAST);

   // A reversal takes priority over a coincident tick, and any state change restarts the step count.
   always_comb begin
      state_nxt = state;
      level_nxt = level;
      cnt_nxt   = cnt;
      if (bus.en) begin
         unique case (state)
            OFF: begin
               cnt_nxt = '0;
               if (bus.led_in) state_nxt = UP;
            end
            UP: begin
               if (!bus.led_in) begin
                  state_nxt = DOWN;
               end else if (tick) begin
                  cnt_nxt = '0;
                  if (level >= PC_LAST) begin
                     level_nxt = MAX;
                     state_nxt = ON;
                  end else begin
                     level_nxt = level + ONE;
                  end
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
            ON: begin
               cnt_nxt = '0;
               if (!bus.led_in) state_nxt = DOWN;
            end
            DOWN: begin
               if (bus.led_in) begin
                  state_nxt = UP;
               end else if (tick) begin
                  cnt_nxt = '0;
                  if (level <= ONE) begin
                     level_nxt = '0;
                     state_nxt = OFF;
                  end else begin
                     level_nxt = level - ONE;
                  end
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
            default: state_nxt = OFF;
         endcase
         if (state_nxt != state) cnt_nxt = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= OFF;
         level  <= '0;
         cnt    <= '0;
         busy_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         level  <= level_nxt;
         cnt    <= cnt_nxt;
         busy_q <= (state_nxt == UP) || (state_nxt == DOWN);
      end
   end

`ifdef LED_PWM_FADER_GAMMA_EN
   logic [2*PWM_BITS-1:0] lvl_w, sq;
   logic [PWM_BITS-1:0]   duty_q;

   // level*(level+1) >> N keeps both endpoints exact: MAX*(MAX+1) = MAX << N.
   assign lvl_w = {{PWM_BITS{1'b0}}, level};
   assign sq    = lvl_w * (lvl_w + (2*PWM_BITS)'(1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) duty_q <= '0;
      else      duty_q <= sq[2*PWM_BITS-1:PWM_BITS];
   end
   assign duty = duty_q;
`else
   assign duty = level;
`endif

   // Period of MAX cycles so duty=MAX is a solid 1 and duty=0 a solid 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc    <= '0;
         led_q <= 1'b0;
      end else begin
         if (!bus.en)           pc <= '0;
         else if (pc == PC_LAST) pc <= '0;
         else                   pc <= pc + ONE;
         led_q <= bus.en & (pc < duty);
      end
   end

   assign bus.led   = led_q;
   assign bus.level = level;
   assign bus.busy  = busy_q;
endmodule
